uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
Serial receive stage that feeds the APB UART wrapper. It oversamples rx_i with a programmable bit-period divider, validates the start bit, and shifts in 5-8 data bits LSB-first, with optional even parity and 1 or 2 stop bits. Each received byte is presented on a valid/ready handshake, alongside per-frame error flags and sticky status flags. The APB wrapper reads the byte from rx_data and clears the status flags.

Parameters:
DIV_WIDTH, 16, width of the cfg_div bit-period divider input.
SYNC_STAGES, 2, number of flip-flops in the rx_i synchroniser (allowed values 2 or 3).

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
rx_i  input  1  asynchronous serial line; idle level is high
cfg_div  input  DIV_WIDTH  CLK cycles per bit; values below 4 treated as 4
cfg_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits
cfg_parity_en  input  1  1 = one even-parity bit follows the data bits
cfg_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
rx_data  output  8  received byte, right-aligned; unused upper bits are 0
rx_valid  output  1  rx_data and the per-frame flags are valid
rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready
rx_perr  output  1  parity error for the presented frame
rx_ferr  output  1  framing error (a stop bit sampled low) for the presented frame
parity_err_o  output  1  sticky parity error
frame_err_o  output  1  sticky framing error
overrun_o  output  1  sticky overrun
clr_err_i  input  1  one-cycle pulse that clears all sticky flags
busy_o  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (RST=1 at a rising edge):
  - state goes to IDLE; synchroniser flops go to 1.
  - all outputs go to 0, including rx_data and all flags.
  - reset aborts any frame in progress; no partial byte is ever delivered.
- Synchroniser: rx_i passes through SYNC_STAGES flops to give rxs. A start condition is rxs=0 while in IDLE.
- Configuration (cfg_div, cfg_bits, cfg_parity_en, cfg_stop_bits):
  - latched on entry to START.
  - changes during a frame take effect on the next frame.
- Bit timer: down-counter, DIV_WIDTH bits wide.
  - START loads floor(div/2)-1, so the start bit is sampled at its midpoint.
  - every later bit loads div-1.
  - a sample is taken when the counter reaches 0.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE -> START on rxs=0.
  - START sample: rxs=1 is a false start, go back to IDLE with no flags; otherwise go to DATA with bit index 0.
  - DATA: shift the sample into bit[index]. After the last bit (4+cfg_bits), go to PARITY if parity is enabled, else STOP1.
  - PARITY: perr = sample XOR (XOR of the data bits); go to STOP1.
  - STOP1: ferr = ~sample. Go to STOP2 if two stop bits, else complete.
  - STOP2: ferr |= ~sample, then complete.
  - Completion: if ferr=1 and rxs=0, go to WAIT_HIGH (break condition), else IDLE. WAIT_HIGH -> IDLE on rxs=1, so no false start is taken during a break.
- Completion output, registered, in the cycle after the final stop sample:
  - rx_data, rx_perr and rx_ferr are loaded and rx_valid is set.
  - sticky parity_err_o and frame_err_o are ORed with the new frame's flags.
- Handshake:
  - rx_valid stays high and data stays stable until the cycle of rx_valid & rx_ready; rx_valid drops in the next cycle.
  - Completion with rx_valid=1 and rx_ready=0: the new frame is dropped, old data is retained, and overrun_o is set.
  - Completion in the same cycle as an accept: new data is loaded, rx_valid stays 1, no overrun.
- Sticky flags: clr_err_i clears them. If clr_err_i and a new set event coincide, set wins.
- Latency: from the rx_i falling edge to rx_valid = SYNC_STAGES + 1 + floor(div/2) + (frame bits after start)*div cycles, ±1 cycle.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each sample is the majority of rxs at timer counts 1, 0 and the cycle after 0; the state advance waits that extra cycle, and all subsequent bits shift by the same cycle.
- Undefined: a single sample of rxs is taken at count 0.
- Latency with the macro defined is 1 cycle longer.

Test Plan:
- Reset then idle: rx_i held high for 1000 cycles -> rx_valid=0, busy_o=0, all flags 0.
- div=16, 8N1, send 0xA5, rx_ready=1 -> a single rx_valid pulse with rx_data=0xA5, perr=0, ferr=0, about 155 cycles after the start edge.
- div=16, 7E2, send 0x3C with correct parity, then 0x3C with the parity bit flipped -> first frame perr=0; second frame rx_perr=1 and parity_err_o=1; clr_err_i pulse then clears parity_err_o.
- Glitch: rx_i low for 4 cycles (div=16) -> false start, back to IDLE, no rx_valid, no flags.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun_o=1. Then raise rx_ready -> one accept; 0x22 is never presented.
- Break: rx_i held low for 3 frames -> one frame delivered with rx_data=0x00 and rx_ferr=1; state stays in WAIT_HIGH until rx_i returns high; a following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receive stage.
// Synchronises rx_i, times each bit with a programmable divider, deframes
// 5-8 data bits LSB-first with optional even parity and 1/2 stop bits, and
// presents each byte on a valid/ready handshake with per-frame and sticky
// error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of rxs at timer counts 1, 0 and the cycle after 0 (one cycle more latency).
module uart_rx_deframer #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_bits,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_stop_bits,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clr_err_i,
  output logic                 busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [DIV_WIDTH-1:0]   div_eff, div_q, cnt;
  logic [1:0]             bits_q;
  logic                   par_q, stop2_q;
  logic [2:0]             idx_q;
  logic [7:0]             data_q;
  logic                   perr_q, ferr_q;
  logic                   start_det, timing, tick, sample, last_bit;
  logic                   done, done_ferr, accept;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign div_eff   = (cfg_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div;
  assign start_det = (state == IDLE) && !rxs;
  assign timing    = (state == START) || (state == DATA) || (state == PARITY) ||
                     (state == STOP1) || (state == STOP2);
  assign last_bit  = (idx_q == ({1'b0, bits_q} + 3'd4));
  assign accept    = rx_valid & rx_ready;
  assign busy_o    = (state != IDLE);

  // Line synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  // Latch frame configuration on start detection so mid-frame changes wait.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= DIV_WIDTH'(4);
      bits_q  <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else if (start_det) begin
      div_q   <= div_eff;
      bits_q  <= cfg_bits;
      par_q   <= cfg_parity_en;
      stop2_q <= cfg_stop_bits;
    end
  end

  // Bit timer: half period to the start-bit midpoint, full periods afterwards.
  always_ff @(posedge CLK) begin
    if (RST)                 cnt <= '0;
    else if (start_det)      cnt <= (div_eff >> 1) - DIV_WIDTH'(1);
    else if (timing) begin
      if (cnt == '0)         cnt <= div_q - DIV_WIDTH'(1);
      else                   cnt <= cnt - DIV_WIDTH'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s1_q, s0_q, pend_q;
  // Capture the two early votes; the bit resolves one cycle after count 0
  // while the timer keeps its period, so every later bit shifts by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      pend_q <= timing && (cnt == '0);
      if (cnt == DIV_WIDTH'(1)) s1_q <= rxs;
      if (cnt == '0)            s0_q <= rxs;
    end
  end
  assign tick   = pend_q && timing;
  assign sample = (s1_q & s0_q) | (s1_q & rxs) | (s0_q & rxs);
`else
  assign tick   = timing && (cnt == '0);
  assign sample = rxs;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and frame completion detect.
  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    done_ferr = 1'b0;
    case (state)
      IDLE:      if (!rxs) state_nx = START;
      START:     if (tick) state_nx = sample ? IDLE : DATA;
      DATA:      if (tick && last_bit) state_nx = par_q ? PARITY : STOP1;
      PARITY:    if (tick) state_nx = STOP1;
      STOP1:     if (tick) begin
                   if (stop2_q) state_nx = STOP2;
                   else begin
                     done      = 1'b1;
                     done_ferr = ~sample;
                   end
                 end
      STOP2:     if (tick) begin
                   done      = 1'b1;
                   done_ferr = ferr_q | ~sample;
                 end
      WAIT_HIGH: if (rxs) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    // A framing error with the line still low is a break: hold until it rises.
    if (done) state_nx = (done_ferr && !rxs) ? WAIT_HIGH : IDLE;
  end

  // Shift data bits in, evaluate parity and the first stop bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      idx_q  <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (start_det) begin
      data_q <= '0;
      idx_q  <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (tick) begin
      case (state)
        DATA: begin
          data_q[idx_q] <= sample;
          idx_q         <= idx_q + 3'd1;
        end
        PARITY:  perr_q <= sample ^ (^data_q);
        STOP1:   ferr_q <= ~sample;
        default: ;
      endcase
    end
  end

  // Output holding register, handshake and sticky flags (set beats clear).
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_perr      <= 1'b0;
      rx_ferr      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (done && (!rx_valid || accept)) begin
        rx_data  <= data_q;
        rx_perr  <= perr_q;
        rx_ferr  <= done_ferr;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      if (done && perr_q)                    parity_err_o <= 1'b1;
      else if (clr_err_i)                    parity_err_o <= 1'b0;
      if (done && done_ferr)                 frame_err_o  <= 1'b1;
      else if (clr_err_i)                    frame_err_o  <= 1'b0;
      if (done && rx_valid && !accept)       overrun_o    <= 1'b1;
      else if (clr_err_i)                    overrun_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized bench for uart_rx_deframer. Frames are built from
// the serial-format rules and compared against captured handshake output.
module tb_uart_rx_deframer;
  localparam int DW = 16;
  localparam int SS = 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST, rx_i, rx_ready, clr_err_i;
  logic [DW-1:0] cfg_div;
  logic [1:0]    cfg_bits;
  logic          cfg_parity_en, cfg_stop_bits;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_perr, rx_ferr;
  logic          parity_err_o, frame_err_o, overrun_o, busy_o;

  uart_rx_deframer #(.DIV_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST), .rx_i(rx_i), .cfg_div(cfg_div), .cfg_bits(cfg_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_stop_bits(cfg_stop_bits),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .clr_err_i(clr_err_i),
    .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Accepted frames: {perr, ferr, data} and the cycle they were seen.
  logic [9:0] cap_q[$];
  int         capc_q[$];
  always @(negedge CLK) begin
    if (!RST && rx_valid && rx_ready) begin
      cap_q.push_back({rx_perr, rx_ferr, rx_data});
      capc_q.push_back(cyc);
    end
  end

  // Reference expectations.
  logic [9:0] exp_q[$];
  int         lat_q[$];
  int         t0_q[$];
  logic       m_perr_st, m_ferr_st;

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    nchk++;
    assert (obs === ex) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, ex);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic clr_pulse();
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    m_perr_st = 1'b0;
    m_ferr_st = 1'b0;
  endtask

  // Serialise one frame; flip inverts the parity bit. Queues the expected result.
  task automatic send_frame(input logic [7:0] data, input int nb, input int pen,
                            input int flip, input int st2, input int d, input int chk_lat);
    int         de, nframe;
    logic [7:0] m;
    logic       pbit, perr;
    de            = (d < 4) ? 4 : d;
    cfg_div       = DW'(d);
    cfg_bits      = 2'(nb - 5);
    cfg_parity_en = (pen != 0);
    cfg_stop_bits = (st2 != 0);
    tick(2);
    m = 8'h00;
    for (int i = 0; i < nb; i++) m[i] = data[i];
    pbit = ($countones(m) % 2 == 1) ^ (flip != 0);
    perr = (pen != 0) && ($countones({pbit, m}) % 2 == 1);
    nframe = nb + pen + 1 + st2;
    t0_q.push_back(cyc);
    exp_q.push_back({perr, 1'b0, m});
    lat_q.push_back(chk_lat ? (SS + 1 + de / 2 + nframe * de + MAJ) : -1);
    m_perr_st = m_perr_st | perr;
    rx_i = 1'b0;
    tick(de);
    for (int i = 0; i < nb; i++) begin
      rx_i = m[i];
      tick(de);
    end
    if (pen != 0) begin
      rx_i = pbit;
      tick(de);
    end
    rx_i = 1'b1;
    tick(de * (1 + st2));
  endtask

  // Wait (bounded) for one accepted frame and compare it with the model.
  task automatic check_frame(input string tag);
    int         w, el, t0, meas;
    logic [9:0] got, ex;
    w = 0;
    while (cap_q.size() == 0 && w < 3000) begin
      tick(1);
      w++;
    end
    check({tag, "_present"}, (cap_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      el = lat_q.pop_front();
      t0 = t0_q.pop_front();
      if (cap_q.size() > 0) begin
        got  = cap_q.pop_front();
        meas = capc_q.pop_front() - t0;
        check({tag, "_data"}, got[7:0], ex[7:0]);
        check({tag, "_perr"}, got[9], ex[9]);
        check({tag, "_ferr"}, got[8], ex[8]);
        if (el >= 0) begin
          nchk++;
          assert (meas >= el - 1 && meas <= el + 1) else begin
            nfail++;
            $error("FAIL %s_latency: got %0d expected %0d+-1", tag, meas, el);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, nb, pen, flip, st2;
    logic [7:0] b;
    RST = 1'b1; rx_i = 1'b1; rx_ready = 1'b1; clr_err_i = 1'b0;
    cfg_div = DW'(16); cfg_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
    m_perr_st = 1'b0; m_ferr_st = 1'b0;
    tick(4);
    RST = 1'b0;
    tick(1);
    check("reset_outs", {rx_data, rx_valid, rx_perr, rx_ferr, parity_err_o,
                         frame_err_o, overrun_o, busy_o}, 0);

    // Long idle with the line high.
    tick(1000);
    check("idle_outs", {rx_valid, rx_perr, rx_ferr, parity_err_o, frame_err_o,
                        overrun_o, busy_o}, 0);
    check("idle_nocap", cap_q.size(), 0);

    // 8N1 0xA5 at div 16.
    send_frame(8'hA5, 8, 0, 0, 0, 16, 1);
    check_frame("a5_8n1");
    check("a5_single", cap_q.size(), 0);

    // 7E2: good parity, then flipped parity; clear sticky.
    send_frame(8'h3C, 7, 1, 0, 1, 16, 1);
    check_frame("3c_7e2_ok");
    check("perr_sticky_ok", parity_err_o, m_perr_st);
    send_frame(8'h3C, 7, 1, 1, 1, 16, 1);
    check_frame("3c_7e2_bad");
    check("perr_sticky_set", parity_err_o, m_perr_st);
    clr_pulse();
    tick(1);
    check("perr_sticky_clr", parity_err_o, 0);

    // Short glitch must be rejected as a false start.
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    tick(60);
    check("glitch_nocap", cap_q.size(), 0);
    check("glitch_state", {busy_o, rx_valid, parity_err_o, frame_err_o, overrun_o}, 0);

    // Overrun: second frame dropped while the first is still held.
    rx_ready = 1'b0;
    send_frame(8'h11, 8, 0, 0, 0, 16, 0);
    send_frame(8'h22, 8, 0, 0, 0, 16, 0);
    tick(5);
    check("ovr_valid", rx_valid, 1);
    check("ovr_hold", rx_data, 8'h11);
    check("ovr_flag", overrun_o, 1);
    rx_ready = 1'b1;
    check_frame("ovr_first");
    exp_q.delete(); lat_q.delete(); t0_q.delete();
    tick(50);
    check("ovr_no22", cap_q.size(), 0);
    check("ovr_vdrop", rx_valid, 0);
    check("ovr_sticky", overrun_o, 1);
    clr_pulse();
    tick(1);
    check("ovr_clr", overrun_o, 0);

    // Break: line low for three 8N1 frames at div 16.
    cfg_div = DW'(16); cfg_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
    tick(2);
    t0_q.push_back(cyc);
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    lat_q.push_back(SS + 1 + 8 + 9 * 16 + MAJ);
    m_ferr_st = 1'b1;
    rx_i = 1'b0;
    tick(3 * 10 * 16);
    check_frame("break");
    check("break_busy", busy_o, 1);
    check("break_fsticky", frame_err_o, m_ferr_st);
    check("break_once", cap_q.size(), 0);
    rx_i = 1'b1;
    tick(10);
    check("break_release", busy_o, 0);
    clr_pulse();
    send_frame(8'h5A, 8, 0, 0, 0, 16, 1);
    check_frame("after_break");
    check("after_break_fst", frame_err_o, 0);

    // Reset in the middle of a frame delivers nothing.
    rx_i = 1'b0;
    tick(60);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    rx_i = 1'b1;
    tick(200);
    check("midrst_nocap", cap_q.size(), 0);
    check("midrst_state", {busy_o, rx_valid}, 0);

    // Randomized frames, including divider values below the floor of 4.
    for (int k = 0; k < 12; k++) begin
      d    = $urandom_range(2, 20);
      nb   = $urandom_range(5, 8);
      pen  = $urandom_range(0, 1);
      flip = (pen != 0) ? $urandom_range(0, 1) : 0;
      st2  = $urandom_range(0, 1);
      b    = 8'($urandom_range(0, 255));
      send_frame(b, nb, pen, flip, st2, d, 1);
      check_frame("rand");
      check("rand_psticky", parity_err_o, m_perr_st);
      if ($urandom_range(0, 1) == 1) clr_pulse();
      tick(8);
    end
    check("rand_fsticky", frame_err_o, 0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
